// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, FSM state
// codes and the datapath select/error field encodings.
package cu_pkg;

  localparam int unsigned OPC_W = 6;
  localparam int unsigned ST_W  = 4;

  // Opcode field values (instruction bits [31:26])
  localparam logic [OPC_W-1:0] R_TYPE = 6'b000000;
  localparam logic [OPC_W-1:0] LW     = 6'b100011;
  localparam logic [OPC_W-1:0] SW     = 6'b101011;
  localparam logic [OPC_W-1:0] BEQ    = 6'b000100;
  localparam logic [OPC_W-1:0] BNE    = 6'b000101;
  localparam logic [OPC_W-1:0] J      = 6'b000010;
  localparam logic [OPC_W-1:0] ADDIU  = 6'b001001;
  localparam logic [OPC_W-1:0] ANDI   = 6'b001100;
  localparam logic [OPC_W-1:0] ORI    = 6'b001101;
  localparam logic [OPC_W-1:0] SLTI   = 6'b001010;

  // FSM state encodings (visible on state_dbg)
  localparam logic [ST_W-1:0] S_INIT     = 4'd0;
  localparam logic [ST_W-1:0] S_FETCH    = 4'd1;
  localparam logic [ST_W-1:0] S_DECODE   = 4'd2;
  localparam logic [ST_W-1:0] S_MEM_ADDR = 4'd3;
  localparam logic [ST_W-1:0] S_MEM_RD   = 4'd4;
  localparam logic [ST_W-1:0] S_MEM_WB   = 4'd5;
  localparam logic [ST_W-1:0] S_MEM_WR   = 4'd6;
  localparam logic [ST_W-1:0] S_R_EXEC   = 4'd7;
  localparam logic [ST_W-1:0] S_R_WB     = 4'd8;
  localparam logic [ST_W-1:0] S_BRANCH   = 4'd9;
  localparam logic [ST_W-1:0] S_JUMP     = 4'd10;
  localparam logic [ST_W-1:0] S_I_EXEC   = 4'd11;
  localparam logic [ST_W-1:0] S_I_WB     = 4'd12;
  localparam logic [ST_W-1:0] S_ERR      = 4'd13;

  // ALU operation select
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_IMM   = 2'b11;

  // ALU operand B select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Error codes
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/multicycle_cu.sv
// Multi-cycle MIPS control unit: Moore sequencing FSM driving a shared-ALU,
// single-memory datapath, with a mem_ready handshake, memory-wait timeout and
// illegal-opcode trap.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   op_code                opcode from the instruction register (used in DECODE only)
//   mem_ready              memory completes the current access this cycle
//   pc_write..pc_source    datapath enables and selects
//   err_code               00 none, 01 illegal opcode, 10 memory timeout (sticky)
//   state_dbg              current state encoding
module multicycle_cu
  import cu_pkg::*;
#(
  parameter int unsigned OP_W        = 6,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] op_code,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            pc_write_cond_ne,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            mem_to_reg,
  output logic            reg_dst,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_source,
  output logic [1:0]      err_code,
  output logic [3:0]      state_dbg
);

  localparam bit               TO_EN     = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [ST_W-1:0]  state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       err_q, err_d;
  logic             wait_st_c;
  logic             timeout_c;

  // State, latched opcode, wait counter and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      op_q    <= '0;
      cnt_q   <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign wait_st_c = state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  // Last permitted wait cycle with memory still not ready
  assign timeout_c = TO_EN && (cnt_q == CNT_LIMIT) && !mem_ready;

  // Next state and state-decoded outputs
  always_comb begin
    state_d          = state_q;
    op_d             = op_q;
    err_d            = err_q;
    pc_write         = 1'b0;
    pc_write_cond    = 1'b0;
    pc_write_cond_ne = 1'b0;
    iord             = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    ir_write         = 1'b0;
    mem_to_reg       = 1'b0;
    reg_dst          = 1'b0;
    reg_write        = 1'b0;
    alu_src_a        = 1'b0;
    alu_src_b        = SRCB_REG;
    alu_op           = ALU_ADD;
    pc_source        = PCSRC_ALU;
    case (state_q)
      S_INIT: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        // IR and PC+4 commit only in the cycle the fetch completes
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_c) begin
          state_d = S_ERR;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        op_d      = op_code;
        case (op_code)
          OP_W'(R_TYPE):                              state_d = S_R_EXEC;
          OP_W'(LW), OP_W'(SW):                       state_d = S_MEM_ADDR;
          OP_W'(BEQ), OP_W'(BNE):                     state_d = S_BRANCH;
          OP_W'(J):                                   state_d = S_JUMP;
          OP_W'(ADDIU), OP_W'(ANDI), OP_W'(ORI), OP_W'(SLTI): state_d = S_I_EXEC;
          default: begin
            state_d = S_ERR;
            err_d   = ERR_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (op_q == OP_W'(LW)) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (timeout_c) begin
          state_d = S_ERR;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (timeout_c) begin
          state_d = S_ERR;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a        = 1'b1;
        alu_op           = ALU_SUB;
        pc_source        = PCSRC_ALUOUT;
        pc_write_cond    = (op_q == OP_W'(BEQ));
        pc_write_cond_ne = (op_q == OP_W'(BNE));
        state_d          = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        state_d   = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = (op_q == OP_W'(ADDIU)) ? ALU_ADD : ALU_IMM;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_ERR:   state_d = S_ERR;
      // Unused encodings fall back to a clean restart
      default: state_d = S_INIT;
    endcase
  end

  // Wait counter: counts while parked in a wait state, cleared on any state change
  always_comb begin
    cnt_d = '0;
    if (wait_st_c && (state_d == state_q) && !mem_ready) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  assign err_code  = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Self-checking bench for multicycle_cu. Each instruction is expanded into the
// cycle-by-cycle list of states it should visit (from the latency and wait
// rules), each state is mapped to its required outputs, and the DUT is
// compared every cycle. A directed table, hand-written corner cases and a
// randomized instruction stream all use the same expansion.
module tb_multicycle_cu;

  localparam int unsigned TO = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001001;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op_code = '0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, pc_write_cond_ne, iord, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source, err_code;
  logic [3:0] state_dbg;
  logic [22:0] dut_vec;

  int n_checks = 0;
  int n_fail   = 0;

  int         q_st[$];
  logic       q_rdy[$];
  logic [1:0] q_err[$];

  int prev_st = 0;
  int cyc_cnt = 0;
  int lat_last = 0;

  multicycle_cu #(.OP_W(6), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_write_cond_ne(pc_write_cond_ne),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .err_code(err_code), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign dut_vec = {pc_write, pc_write_cond, pc_write_cond_ne, iord, mem_read, mem_write,
                    ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                    alu_src_b, alu_op, pc_source, err_code, state_dbg};

  // Cycles spent between consecutive entries into FETCH (one instruction's latency)
  always @(negedge clk) begin
    if (state_dbg == 4'd1 && prev_st != 1) begin
      lat_last = cyc_cnt;
      cyc_cnt  = 1;
    end else begin
      cyc_cnt++;
    end
    prev_st = int'(state_dbg);
  end

  // Required outputs for a state, in the same bit order as dut_vec
  function automatic logic [22:0] exp_vec(input int st, input logic [5:0] op,
                                          input logic rdy, input logic [1:0] err);
    logic pw, pwc, pwn, io, mr, mw, irw, m2r, rd, rw, asa;
    logic [1:0] asb, aop, pcs;
    {pw, pwc, pwn, io, mr, mw, irw, m2r, rd, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      1:  begin mr = 1; asb = 2'b01; pw = rdy; irw = rdy; end
      2:  asb = 2'b11;
      3:  begin asa = 1; asb = 2'b10; end
      4:  begin mr = 1; io = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin mw = 1; io = 1; end
      7:  begin asa = 1; aop = 2'b10; end
      8:  begin rd = 1; rw = 1; end
      9:  begin asa = 1; aop = 2'b01; pcs = 2'b01; pwc = (op == OP_BEQ); pwn = (op == OP_BNE); end
      10: begin pw = 1; pcs = 2'b10; end
      11: begin asa = 1; asb = 2'b10; aop = (op == OP_ADDI) ? 2'b00 : 2'b11; end
      12: rw = 1;
      default: ;
    endcase
    return {pw, pwc, pwn, io, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, err, 4'(st)};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  task automatic push(input int st, input logic rdy, input logic [1:0] err);
    q_st.push_back(st);
    q_rdy.push_back(rdy);
    q_err.push_back(err);
  endtask

  // w not-ready cycles then ready; w >= TO instead hits the timeout into ERR
  task automatic push_wait(input int st, input int w, output bit to);
    to = 1'b0;
    if (TO != 0 && w >= int'(TO)) begin
      for (int i = 0; i < int'(TO); i++) push(st, 1'b0, 2'b00);
      push(13, 1'($urandom), 2'b10);
      to = 1'b1;
    end else begin
      for (int i = 0; i < w; i++) push(st, 1'b0, 2'b00);
      push(st, 1'b1, 2'b00);
    end
  endtask

  task automatic do_reset(input bit now);
    if (!now) begin
      @(negedge clk);
      #2;
    end
    rst_n = 1'b0;
    #1 check("reset_outputs", 32'(dut_vec), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("init_after_reset", 32'(dut_vec), 32'd0);
  endtask

  // Expand one instruction into its state sequence, drive it and check every cycle
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input int n_err, input int abort_st, input int prev_lat);
    bit to;
    q_st.delete(); q_rdy.delete(); q_err.delete();
    push_wait(1, fw, to);
    if (!to) begin
      push(2, 1'($urandom), 2'b00);
      case (op)
        OP_R:   begin push(7, 1'($urandom), 2'b00); push(8, 1'($urandom), 2'b00); end
        OP_LW:  begin
          push(3, 1'($urandom), 2'b00);
          push_wait(4, mw, to);
          if (!to) push(5, 1'($urandom), 2'b00);
        end
        OP_SW:  begin push(3, 1'($urandom), 2'b00); push_wait(6, mw, to); end
        OP_BEQ, OP_BNE: push(9, 1'($urandom), 2'b00);
        OP_J:   push(10, 1'($urandom), 2'b00);
        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
          push(11, 1'($urandom), 2'b00); push(12, 1'($urandom), 2'b00);
        end
        default: begin push(13, 1'($urandom), 2'b01); to = 1'b1; end
      endcase
    end
    if (to) begin
      for (int i = 0; i < n_err; i++) push(13, 1'($urandom), q_err[q_err.size()-1]);
    end
    for (int i = 0; i < q_st.size(); i++) begin
      @(negedge clk);
      op_code   = (q_st[i] == 2) ? op : 6'($urandom);
      mem_ready = q_rdy[i];
      #1;
      if (i == 0 && prev_lat > 0) check("latency", 32'(lat_last), 32'(prev_lat));
      check($sformatf("op%02h_step%0d_st%0d", op, i, q_st[i]), 32'(dut_vec),
            32'(exp_vec(q_st[i], op, q_rdy[i], q_err[i])));
      if (q_st[i] == abort_st) begin
        #1;
        rst_n = 1'b0;
        #1 check("abort_mem_write", 32'(mem_write), 32'd0);
        check("abort_outputs", 32'(dut_vec), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("abort_init", 32'(dut_vec), 32'd0);
        return;
      end
    end
    if (to) do_reset(1'b0);
  endtask

  typedef struct {
    logic [5:0] op;
    int         fw;
    int         mw;
    int         lat;   // FETCH-to-FETCH cycles; 0 for runs ending in ERR
  } vec_t;

  initial begin
    vec_t tbl[18];
    logic [5:0] ops[10];
    int prev;
    logic [5:0] rop;
    int rfw, rmw;

    tbl = '{
      '{OP_R,    0, 0, 4}, '{OP_LW,   0, 0, 5}, '{OP_SW,   0, 0, 4},
      '{OP_BEQ,  0, 0, 3}, '{OP_BNE,  0, 0, 3}, '{OP_J,    0, 0, 3},
      '{OP_ADDI, 0, 0, 4}, '{OP_ANDI, 0, 0, 4}, '{OP_ORI,  0, 0, 4},
      '{OP_SLTI, 0, 0, 4}, '{OP_LW,   0, 3, 8}, '{OP_SW,   2, 1, 7},
      '{OP_R,    3, 0, 7}, '{OP_BEQ,  1, 0, 4}, '{OP_R,    4, 0, 0},
      '{6'h3f,   0, 0, 0}, '{OP_LW,   0, 4, 0}, '{OP_SW,   0, 5, 0}
    };
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};

    // Reset held from time zero, then released
    #1 check("reset_hold", 32'(dut_vec), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("init_state", 32'(dut_vec), 32'd0);

    // Directed table
    prev = 0;
    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].fw, tbl[i].mw, 3, -1, prev);
      prev = tbl[i].lat;
    end

    // Illegal opcode: ERR stays put for 50 cycles, then reset clears err_code
    run_instr(6'b111111, 0, 0, 50, -1, 0);
    // Asynchronous reset in the middle of a store
    run_instr(OP_SW, 0, 2, 0, 6, 0);
    // Back-to-back bne then beq with latency check across them
    run_instr(OP_BNE, 0, 0, 0, -1, 0);
    run_instr(OP_BEQ, 0, 0, 0, -1, 3);
    run_instr(OP_R,   0, 0, 0, -1, 3);

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      rop = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      rfw = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 2);
      rmw = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
      run_instr(rop, rfw, rmw, 2, -1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_cu.md
Name: multicycle_cu

Overview:
- Multi-cycle MIPS control unit. Replaces the single-cycle opcode decoder with a sequencing FSM.
- Supports the same instruction set: R-type, lw, sw, beq, bne, j, addiu, andi, ori, slti.
- Adds variable-latency memory handshake (mem_ready), a parametrised memory timeout, and illegal-opcode trapping.
- Sits between the instruction register and the shared-ALU/single-memory datapath.

Parameters:
- OP_W, 6, opcode width.
- MEM_TIMEOUT, 16, max consecutive cycles mem_ready may stay low in a memory-wait state. 0 disables the timeout.
- CNT_W, $clog2(MEM_TIMEOUT+1) (min 1), timeout counter width.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_code  in  OP_W  opcode field from the instruction register.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (beq).
- pc_write_cond_ne  out  1  PC load if ALU not-zero (bne).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  write-back select: 1 = MDR.
- reg_dst  out  1  destination select: 1 = rd, 0 = rt.
- reg_write  out  1  register file write.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded, 11 = immediate-op decoded.
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- err_code  out  2  00 = none, 01 = illegal opcode, 10 = memory timeout.
- state_dbg  out  4  current state encoding.

Behaviour:
- Moore FSM with 4-bit state. Outputs decode from state, except pc_write/ir_write in FETCH, which are qualified by mem_ready.
- Async reset → INIT. During reset all outputs are 0, err_code = 00, op_q = 0, counter = 0.
- Reset mid-instruction aborts it immediately; no enables remain asserted.
- Any output not listed for a state is 0.
- State sequence and outputs:
  - INIT(0): all outputs 0 → FETCH.
  - FETCH(1): mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
    - ir_write = pc_write = mem_ready.
    - mem_ready → DECODE; else stay.
  - DECODE(2): alu_src_a=0, alu_src_b=11, alu_op=00. Latch op_q <= op_code.
    - R → R_EXEC; lw/sw → MEM_ADDR; beq/bne → BRANCH; j → JUMP; addiu/andi/ori/slti → I_EXEC.
    - Any other opcode → ERR with err_code=01.
  - MEM_ADDR(3): alu_src_a=1, alu_src_b=10, alu_op=00. op_q=lw → MEM_RD; sw → MEM_WR.
  - MEM_RD(4): mem_read=1, iord=1. mem_ready → MEM_WB.
  - MEM_WB(5): reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH.
  - MEM_WR(6): mem_write=1, iord=1. mem_ready → FETCH.
  - R_EXEC(7): alu_src_a=1, alu_src_b=00, alu_op=10 → R_WB.
  - R_WB(8): reg_dst=1, reg_write=1 → FETCH.
  - BRANCH(9): alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01.
    - pc_write_cond = (op_q==beq); pc_write_cond_ne = (op_q==bne).
    - → FETCH.
  - JUMP(10): pc_write=1, pc_source=10 → FETCH.
  - I_EXEC(11): alu_src_a=1, alu_src_b=10; alu_op=00 for addiu, 11 for andi/ori/slti → I_WB.
  - I_WB(12): reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.
  - ERR(13): all enables 0; err_code held. Sticky until rst_n.
- Instruction latencies with mem_ready=1 throughout: R/I-type 4 cycles, lw 5, sw 4, branch 3, j 3. Each cycle of mem_ready=0 adds 1.
- Timeout counter:
  - Cleared on entry to FETCH/MEM_RD/MEM_WR.
  - Increments each wait cycle with mem_ready=0, saturating.
  - If count == MEM_TIMEOUT-1 and mem_ready=0 → ERR with err_code=10.
  - mem_ready=1 on the limit cycle: ready wins, normal transition.
- op_code is ignored outside DECODE.

Decomposition:
- Package cu_pkg holds:
  - opcode localparams (R_TYPE, LW, SW, BEQ, BNE, J, ADDIU, ANDI, ORI, SLTI);
  - state encodings;
  - alu_op, alu_src_b, pc_source and err_code encodings.
- Single module; the timeout counter is small enough to stay inline, no sub-module.

Test Plan:
- Reset released, mem_ready=1, op_code=000000:
  - state_dbg 0→1→2→7→8→1;
  - reg_write=1 and reg_dst=1 only in R_WB.
- lw (100011), mem_ready low 3 cycles in MEM_RD:
  - 8 cycles FETCH→FETCH;
  - mem_to_reg=1 and reg_write=1 for exactly 1 cycle.
- bne (000101):
  - BRANCH shows pc_write_cond_ne=1, pc_write_cond=0, alu_op=01, pc_source=01;
  - beq gives the inverse.
- op_code=111111 at DECODE:
  - next state ERR, err_code=01, outputs 0;
  - stays 50 cycles with mem_ready toggling;
  - rst_n pulse returns to INIT, err_code=00.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH:
  - ERR after 4 FETCH cycles, err_code=10;
  - repeat with mem_ready=1 on the 4th cycle → DECODE, no error.
- rst_n asserted asynchronously mid-MEM_WR:
  - mem_write drops the same cycle;
  - state INIT after release.
